// File: rtl/prog_loader.sv
// Streams a program image into instruction memory, then releases the core from reset.
// Optional checksum verification of the loaded image is enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic [31:0]      cksum_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wd,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t           state, next_state;
  logic [31:0]      base_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx;
  logic             start_ok_c;
  logic             xfer_c;
  logic             last_c;
  logic             too_long_c;
  logic             check_pass_c;

  assign start_ok_c = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERROR);
  assign xfer_c     = s_valid && (state == ST_LOAD);
  assign last_c     = xfer_c && (idx == cnt_q - CNT_W'(1));
  assign too_long_c = {1'b0, word_count} > (CNT_W + 1)'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic [31:0] cksum_q;

  assign check_pass_c = (sum == cksum_q);

  // Running modulo-2^32 sum of accepted words
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum     <= '0;
      cksum_q <= '0;
    end else if (start_ok_c) begin
      sum     <= '0;
      cksum_q <= cksum_in;
    end else if (xfer_c) begin
      sum     <= sum + s_data;
    end
  end

  logic unused_bits;
  assign unused_bits = ^base_addr[1:0];
`else
  assign check_pass_c = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{base_addr[1:0], cksum_in};
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          if (too_long_c)              next_state = ST_ERROR;
          else if (word_count == '0)   next_state = ST_CHECK;
          else                         next_state = ST_LOAD;
        end
      end
      ST_LOAD:  if (last_c) next_state = ST_CHECK;
      ST_CHECK: next_state = check_pass_c ? ST_RUN : ST_ERROR;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; core_reset also rises with a start that leaves RUN
  always_comb begin
    s_ready    = 1'b0;
    busy       = 1'b0;
    error      = 1'b0;
    core_reset = 1'b1;
    case (state)
      ST_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      ST_CHECK: busy       = 1'b1;
      ST_RUN:   core_reset = start;
      ST_ERROR: error      = 1'b1;
      default: ;
    endcase
  end

  assign imem_we   = s_valid && s_ready;
  assign imem_addr = base_q + (32'(idx) << 2);
  assign imem_wd   = s_data;

  // Load descriptor latch and word index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q <= '0;
      cnt_q  <= '0;
      idx    <= '0;
    end else if (start_ok_c) begin
      base_q <= {base_addr[31:2], 2'b00};
      cnt_q  <= word_count;
      idx    <= '0;
    end else if (xfer_c) begin
      idx    <= idx + CNT_W'(1);
    end
  end

  // Single-cycle pulse on the first RUN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done <= 1'b0;
    else        done <= (state == ST_CHECK) && (next_state == ST_RUN);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued at start,
// a monitor pops them on every imem_we; outcome/timing checked by the sequencer.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic [31:0] cksum_in;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  int          n_cmp = 0;
  int          n_err = 0;
  int          we_total = 0;
  logic [31:0] words[$];
  logic [63:0] exp_q[$];

  prog_loader #(.MAX_WORDS(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .cksum_in(cksum_in), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wd(imem_wd), .core_reset(core_reset),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        we_total++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %h data %h, required no write", imem_addr, imem_wd);
        end else begin
          e = exp_q.pop_front();
          chk("imem_addr", imem_addr, e[63:32]);
          chk("imem_wd", imem_wd, e[31:0]);
        end
      end
    end
  endtask

  // Reference: byte address of word i is the word-aligned base plus 4*i
  function automatic logic [31:0] ref_addr(input logic [31:0] base, input int i);
    return (base & 32'hFFFF_FFFC) + 32'(4 * i);
  endfunction

  // All tasks below start and end 1 time unit after a rising edge
  task automatic stream_word(input logic [31:0] data, input int gap);
    bit acc = 0;
    if (gap != 0) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = data;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = (s_ready === 1'b1);
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL stream_timeout: s_ready never 1, required 1 within 20 cycles");
    end
  endtask

  task automatic start_job(input logic [31:0] base, input int n, input bit corrupt,
                           input bit from_run, output bit ok);
    logic [31:0] sum = 0;
    logic [31:0] cks;
    for (int i = 0; i < n && i < words.size(); i++) sum += words[i];
    cks = corrupt ? sum + 32'd1 : sum;
`ifdef LOADER_CHECKSUM_EN
    ok = (n <= 64) && (cks == sum);
`else
    ok = (n <= 64);
`endif
    if (n >= 1 && n <= 64)
      for (int i = 0; i < n; i++) exp_q.push_back({ref_addr(base, i), words[i]});
    start      = 1'b1;
    base_addr  = base;
    word_count = 16'(n);
    cksum_in   = cks;
    if (from_run) begin
      #1;
      chk("core_reset_on_start_in_run", core_reset, 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_job(input int n, input int first, input int gap_mode,
                            input bit ok, input int we0);
    if (n > 64) begin
      @(negedge clk);
      chk("len_error", error, 1);
      chk("len_core_reset", core_reset, 1);
      chk("len_busy", busy, 0);
      chk("len_no_writes", 32'(we_total - we0), 0);
      @(posedge clk); #1;
      return;
    end
    for (int i = first; i < n; i++)
      stream_word(words[i], gap_mode == 2 ? int'($urandom_range(0, 1)) : gap_mode);
    s_valid = 1'b0;
    @(negedge clk);
    chk("check_busy", busy, 1);
    chk("check_no_done", done, 0);
    @(negedge clk);
    chk("outcome_done", done, ok);
    chk("outcome_error", error, !ok);
    chk("outcome_core_reset", core_reset, !ok);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    chk("write_pulses", 32'(we_total - we0), 32'(n));
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic job(input logic [31:0] base, input int n, input bit corrupt,
                     input bit from_run, input int gap_mode);
    bit ok;
    int we0 = we_total;
    start_job(base, n, corrupt, from_run, ok);
    finish_job(n, 0, gap_mode, ok, we0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    int we0;
    reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    cksum_in = '0; s_valid = 1'b0; s_data = '0;
    fork monitor(); join_none

    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_core_reset", core_reset, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Reference program, back-to-back then with toggling valid
    words = '{32'h00500113, 32'h00C00193, 32'hFF718393};
    job(32'h0, 3, 0, 0, 0);
    job(32'h0, 3, 0, 1, 1);
    // Wrong checksum
    job(32'h0, 3, 1, 1, 0);
    // Over-length and empty loads
    job(32'h0, 65, 0, 0, 0);
    words.delete();
    job(32'h40, 0, 0, 0, 0);
    // Unaligned base
    words = '{32'hDEADBEEF, 32'h12345678};
    job(32'h6, 2, 0, 1, 0);

    // Start while loading is ignored
    words = '{32'h11111111, 32'h22222222, 32'h33333333};
    we0 = we_total;
    start_job(32'h100, 3, 0, 1, ok);
    stream_word(words[0], 0);
    s_valid = 1'b0; start = 1'b1; base_addr = 32'h800; word_count = 16'd65;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_load_busy", busy, 1);
    finish_job(3, 1, 0, ok, we0);

    // Reset midway through a 4-word load
    words = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
    we0 = we_total;
    start_job(32'h200, 4, 0, 1, ok);
    stream_word(words[0], 0);
    stream_word(words[1], 0);
    reset = 1'b0;
    s_valid = 1'b1; s_data = words[2];
    #1;
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_imem_we", imem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_core_reset", core_reset, 1);
    chk("midrst_writes", 32'(we_total - we0), 2);
    exp_q.delete();
    #2;
    reset = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    job(32'h200, 4, 0, 0, 0);

    // Randomized loads
    for (int j = 0; j < 8; j++) begin
      int n = int'($urandom_range(1, 8));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      job($urandom, n, bit'($urandom_range(0, 1)), 0, 2);
    end
    // Full-depth boundary load
    words.delete();
    for (int i = 0; i < 64; i++) words.push_back($urandom);
    job(32'hFFFF_FF00, 64, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MAX_WORDS, default 64, is the instruction-memory depth in 32-bit words.
REQ-002 Parameter CNT_W, default 16, is the width of the word counter and of word_count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle load request.
REQ-006 base_addr  input  32  byte address of the first word to load.
REQ-007 word_count  input  CNT_W  number of words to load.
REQ-008 cksum_in  input  32  expected checksum, sampled with start.
REQ-009 s_valid  input  1  the stream word is valid.
REQ-010 s_ready  output  1  the loader accepts a stream word.
REQ-011 s_data  input  32  stream word.
REQ-012 imem_we  output  1  instruction-memory write enable.
REQ-013 imem_addr  output  32  instruction-memory byte address.
REQ-014 imem_wd  output  32  instruction-memory write data.
REQ-015 core_reset  output  1  active-high hold-in-reset for the processor core.
REQ-016 busy  output  1  high in LOAD or CHECK.
REQ-017 done  output  1  one-cycle pulse when the FSM enters RUN.
REQ-018 error  output  1  high in state ERROR.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, CHECK, RUN and ERROR.
REQ-020 On start, if the state is IDLE, RUN or ERROR, the block SHALL do the following:
- latch base_addr with bits [1:0] forced to 0;
- latch word_count and cksum_in;
- clear the word index and the running sum.
REQ-021 On start with word_count > MAX_WORDS, the FSM SHALL go to ERROR.
REQ-022 On start with word_count = 0, the FSM SHALL go to CHECK.
REQ-023 On start with any other word_count, the FSM SHALL go to LOAD.
REQ-024 The block SHALL ignore start while the FSM is in LOAD or CHECK.
REQ-025 s_ready SHALL be 1 only in LOAD.
REQ-026 A transfer SHALL occur when s_valid and s_ready are both 1.
REQ-027 imem_we SHALL equal s_valid AND s_ready (combinational), so each word is written in the cycle it is accepted (zero latency).
REQ-028 imem_addr SHALL equal latched base + 4*index, computed modulo 2^32.
REQ-029 imem_wd SHALL equal s_data.
REQ-030 The index SHALL increment once per transfer.
REQ-031 After the transfer of the last word (index = word_count-1), the FSM SHALL go to CHECK.
REQ-032 Idle cycles with s_valid=0 SHALL change no state.
REQ-033 CHECK SHALL last exactly one cycle, then go to RUN or ERROR as set by the Configuration section.
REQ-034 core_reset SHALL be 0 only in RUN.
REQ-035 core_reset SHALL rise in the same cycle that start takes the FSM out of RUN.
REQ-036 done SHALL be 1 for exactly the first cycle in RUN.
REQ-037 ERROR SHALL persist until the next accepted start.

Reset
REQ-038 While reset=0, the block SHALL asynchronously force state=IDLE, index=0, sum=0, s_ready=0, imem_we=0, busy=0, done=0, error=0 and core_reset=1.
REQ-039 A reset asserted during LOAD SHALL abandon the load; words already written remain in memory.
REQ-040 The FSM SHALL leave IDLE only on start.

Configuration
REQ-041 Macro LOADER_CHECKSUM_EN SHALL control the checksum feature.
REQ-042 With LOADER_CHECKSUM_EN defined, the block SHALL keep a running 32-bit sum of accepted words, modulo 2^32.
REQ-043 With LOADER_CHECKSUM_EN defined, CHECK SHALL go to RUN if the sum equals the latched cksum_in, else to ERROR.
REQ-044 Without LOADER_CHECKSUM_EN, the block SHALL have no sum register, cksum_in SHALL be unused, CHECK SHALL always go to RUN, and ERROR SHALL be reachable only by the length check.

Verification
REQ-045 Reset, then start with base=0x0, count=3, words 0x00500113/0x00C00193/0xFF718393 and cksum matching → writes to addresses 0x0/0x4/0x8, done pulses once, core_reset falls, error=0.
REQ-046 Same load with s_valid toggling every other cycle → identical writes; exactly 3 imem_we pulses.
REQ-047 With LOADER_CHECKSUM_EN, cksum_in off by 1 → ERROR, error=1, core_reset=1; without the macro → RUN.
REQ-048 start with count=65 (MAX_WORDS=64) → ERROR next cycle, no imem_we; start with count=0 → RUN after 2 cycles.
REQ-049 reset driven low after 2 of 4 words → IDLE immediately, core_reset=1, s_ready=0; a new start reloads from index 0.
REQ-050 start in RUN → core_reset=1 same cycle; start during LOAD is ignored; base=0x6 → first write at 0x4.
